// File: rtl/instr_encoder_if.sv
// Handshake bundle for the immediate encoder: request side (imm/base in)
// and response side (packed instruction out), plus the error counter.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_op;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        out_error;
  logic [15:0] err_count;

  modport slave (
    input  in_valid, imm_op, imm, base, out_ready,
    output in_ready, out_valid, instruction, out_error, err_count
  );

  modport master (
    output in_valid, imm_op, imm, base, out_ready,
    input  in_ready, out_valid, instruction, out_error, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs an immediate into a RISC-V instruction word, flags non-representable
// immediates and buffers results in a 2-entry FIFO whose head drives the outputs.
module instr_encoder (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_I = 3'b000,
    OP_S = 3'b001,
    OP_B = 3'b010,
    OP_U = 3'b011,
    OP_J = 3'b100
  } imm_op_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } entry_t;

  entry_t      enc;
  entry_t      head;
  entry_t      tail;
  logic [1:0]  count;
  logic [31:0] imm;
  logic [31:0] base;
  logic        push;
  logic        pop;

  assign imm  = bus.imm;
  assign base = bus.base;

  always_comb begin
    enc.inst = base;
    enc.err  = 1'b0;
    case (imm_op_e'(bus.imm_op))
      OP_I: begin
        enc.inst[31:20] = imm[11:0];
        enc.err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      OP_S: begin
        enc.inst[31:25] = imm[11:5];
        enc.inst[11:7]  = imm[4:0];
        enc.err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      OP_B: begin
        enc.inst[31]    = imm[12];
        enc.inst[30:25] = imm[10:5];
        enc.inst[11:8]  = imm[4:1];
        enc.inst[7]     = imm[11];
        enc.err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      end
      OP_U: begin
        enc.inst[31:12] = imm[31:12];
        enc.err = |imm[11:0];
      end
      OP_J: begin
        enc.inst[31]    = imm[20];
        enc.inst[30:21] = imm[10:1];
        enc.inst[20]    = imm[11];
        enc.inst[19:12] = imm[19:12];
        enc.err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      end
      default: enc.err = 1'b1;
    endcase
  end

  // No pass-through when full: a same-cycle pop does not free a slot.
  assign bus.in_ready = (count < 2'd2) && rst_n;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // head is the output register itself, so it keeps the last popped value
  // while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: if (push) begin
          head  <= enc;
          count <= 2'd1;
        end
        2'd1: begin
          if (push && pop) head <= enc;
          else if (push) begin
            tail  <= enc;
            count <= 2'd2;
          end else if (pop) count <= 2'd0;
        end
        2'd2: if (pop) begin
          head  <= tail;
          count <= 2'd1;
        end
        default: count <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         bus.err_count <= 16'd0;
    else if (push && enc.err && bus.err_count != 16'hFFFF) bus.err_count <= bus.err_count + 16'd1;
  end

  assign bus.out_valid   = (count != 2'd0);
  assign bus.instruction = head.inst;
  assign bus.out_error   = head.err;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomised bench: a queue-based reference checks every head beat by decoding
// it back and comparing non-immediate bits to base.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus();
  instr_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] imm;
    logic [31:0] base;
  } beat_t;

  int          n_chk = 0;
  int          n_pass = 0;
  beat_t       q[$];
  beat_t       last;
  bit          have_last = 0;
  int unsigned ref_err = 0;
  bit          acc;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Immediate value that survives the format's field widths (what a decoder sees).
  function automatic logic [31:0] trunc(logic [2:0] op, logic [31:0] imm);
    logic signed [31:0] s;
    logic signed [31:0] t;
    s = imm;
    case (op)
      3'd0, 3'd1: begin t = (s <<< 20) >>> 20; return t; end
      3'd2:       begin t = (s <<< 19) >>> 19; return t & ~32'd1; end
      3'd3:       return imm & 32'hFFFFF000;
      3'd4:       begin t = (s <<< 11) >>> 11; return t & ~32'd1; end
      default:    return imm;
    endcase
  endfunction

  function automatic logic [31:0] decode(logic [2:0] op, logic [31:0] i);
    case (op)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(logic [2:0] op);
    case (op)
      3'd0:       return 32'hFFF00000;
      3'd1, 3'd2: return 32'hFE000F80;
      default:    return 32'hFFFFF000;
    endcase
  endfunction

  function automatic bit is_err(beat_t b);
    if (b.op > 3'd4) return 1'b1;
    return trunc(b.op, b.imm) != b.imm;
  endfunction

  task automatic check_beat(string tag, beat_t b);
    logic [31:0] m;
    m = imm_mask(b.op);
    chk({tag, ".err"}, 32'(bus.out_error), 32'(is_err(b)));
    if (b.op > 3'd4) chk({tag, ".inst"}, bus.instruction, b.base);
    else begin
      chk({tag, ".fixed"}, bus.instruction & ~m, b.base & ~m);
      chk({tag, ".imm"}, decode(b.op, bus.instruction), trunc(b.op, b.imm));
    end
  endtask

  // One clock: check outputs against the model, drive new inputs, advance model.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] imm,
                       input logic [31:0] base, input logic ordy, output bit accepted);
    beat_t b;
    bit    pop;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("err_count", 32'(bus.err_count), ref_err);
    if (q.size() != 0) check_beat("head", q[0]);
    else if (have_last) check_beat("hold", last);
    else begin
      chk("idle.inst", bus.instruction, 32'd0);
      chk("idle.err", 32'(bus.out_error), 32'd0);
    end
    bus.in_valid  = v;
    bus.imm_op    = op;
    bus.imm       = imm;
    bus.base      = base;
    bus.out_ready = ordy;
    b.op = op; b.imm = imm; b.base = base;
    accepted = v && (q.size() < 2);
    pop = (q.size() != 0) && ordy;
    if (pop) begin last = q.pop_front(); have_last = 1; end
    if (accepted) begin
      q.push_back(b);
      if (is_err(b) && ref_err != 32'hFFFF) ref_err++;
    end
  endtask

  task automatic idle(input logic ordy);
    bit a;
    cycle(1'b0, 3'd0, 32'd0, 32'd0, ordy, a);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return r;
      1: return 32'(signed'(r[11:0]));
      2: return 32'(signed'({r[12:1], 1'b0}));
      3: return r & 32'hFFFFF000;
      4: return 32'(signed'({r[20:1], 1'b0}));
      default: return 32'(signed'(r[12:0]));
    endcase
  endfunction

  initial begin
    bus.in_valid = 0; bus.imm_op = 0; bus.imm = 0; bus.base = 0; bus.out_ready = 0;
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.inst", bus.instruction, 32'd0);
    chk("rst.err_count", 32'(bus.err_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel.in_ready", 32'(bus.in_ready), 32'd1);

    cycle(1, 3'd0, 32'hFFFFF800, 32'h13, 1, acc);
    idle(1);
    chk("t_i.inst", bus.instruction, 32'h80000013);
    chk("t_i.err", 32'(bus.out_error), 32'd0);

    cycle(1, 3'd2, 32'h00000800, 32'h63, 1, acc);
    cycle(1, 3'd3, 32'h12345000, 32'h37, 1, acc);
    chk("t_b.inst", bus.instruction, 32'h000000E3);
    idle(1);
    chk("t_u.inst", bus.instruction, 32'h12345037);
    chk("t_u.err", 32'(bus.out_error), 32'd0);

    cycle(1, 3'd0, 32'h00000800, 32'h13, 1, acc);
    cycle(1, 3'd4, 32'h00000001, 32'h6F, 1, acc);
    chk("e_i.inst", bus.instruction, 32'h80000013);
    chk("e_i.err", 32'(bus.out_error), 32'd1);
    chk("e_i.cnt", 32'(bus.err_count), 32'd1);
    cycle(1, 3'd7, 32'h00000000, 32'hDEADBEEF, 1, acc);
    chk("e_j.err", 32'(bus.out_error), 32'd1);
    chk("e_j.cnt", 32'(bus.err_count), 32'd2);
    idle(1);
    chk("e_7.inst", bus.instruction, 32'hDEADBEEF);
    chk("e_7.cnt", 32'(bus.err_count), 32'd3);
    idle(1);

    // Backpressure: two error beats fill the FIFO, the third waits for a pop.
    cycle(1, 3'd0, 32'h00000800, 32'h00000013, 0, acc);
    cycle(1, 3'd5, 32'h00000123, 32'hCAFEF00D, 0, acc);
    cycle(1, 3'd1, 32'h000007FF, 32'h00000023, 0, acc);
    chk("bp.held", 32'(acc), 32'd0);
    repeat (2) cycle(1, 3'd1, 32'h000007FF, 32'h00000023, 0, acc);
    begin
      int tries = 0;
      acc = 0;
      while (!acc && tries < 10) begin
        cycle(1, 3'd1, 32'h000007FF, 32'h00000023, 1, acc);
        tries++;
      end
      chk("bp.accept", 32'(acc), 32'd1);
    end
    repeat (4) idle(1);

    // Reset with a full FIFO and err_count=5.
    cycle(1, 3'd0, 32'h00000010, 32'h00000013, 0, acc);
    cycle(1, 3'd3, 32'hABCDE000, 32'h00000037, 0, acc);
    idle(0);
    chk("pre_rst.cnt", 32'(bus.err_count), 32'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst.inst", bus.instruction, 32'd0);
    chk("mid_rst.err", 32'(bus.out_error), 32'd0);
    chk("mid_rst.cnt", 32'(bus.err_count), 32'd0);
    chk("mid_rst.in_ready", 32'(bus.in_ready), 32'd0);
    q.delete(); have_last = 0; ref_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1);

    for (int n = 0; n < 10000; n++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cycle(1'($urandom_range(0, 3) != 0), op, rand_imm(), $urandom,
            1'($urandom_range(0, 3) != 0), acc);
    end
    repeat (4) idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
